ll_walk_gen: RTL and testbench
==============================

Name: ll_walk_gen

Overview:
- Parametrised linked-list walker. It replaces the fixed-table request generator used in the msu_linked_list flow.
- Accepts start pointers over a valid/ready handshake and follows a run-time programmable next-pointer table.
- Emits each visited pointer on a valid/ready output stream, marking the final beat of each list.
- Adds three features the fixed generator lacks: output backpressure, a programmable table, and loop protection.

Parameters:
PTR_W, 8, pointer width in bits
DEPTH, 16, next-table entries; power of two, DEPTH <= 2**PTR_W - 1
AW, $clog2(DEPTH), table address width
MAX_HOPS, DEPTH, maximum beats emitted per walk before loop abort
NULL_PTR, {PTR_W{1'b1}}, list terminator value

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (rst=0 resets)
cfg_we  in  1  table write enable
cfg_addr  in  AW  table write index
cfg_next  in  PTR_W  next-pointer value to write
start_ptr  in  PTR_W  head of list to walk
start_vld  in  1  start request valid
start_rdy  out  1  walker can accept a start
out_ptr  out  PTR_W  current visited pointer
out_ptr_vld  out  1  out_ptr valid
out_ptr_rdy  in  1  downstream accepts out_ptr
out_last  out  1  qualifies the beat as the final pointer of this walk
busy  out  1  walk in progress (state WALK)
err_loop  out  1  sticky: a walk was aborted at MAX_HOPS
err_clr  in  1  clears err_loop (synchronous)

Behaviour:
- Reset values (rst=0, async):
  - state=IDLE; all table entries=NULL_PTR; hop_cnt=0; err_loop=0.
  - out_ptr_vld=0, out_ptr=0, out_last=0, busy=0.
  - start_rdy goes to 1 as soon as rst deasserts.
- Reset mid-walk aborts immediately. No partial beat completes.
- FSM states: IDLE, WALK.
- IDLE:
  - start_rdy=1, out_ptr_vld=0.
  - On start_vld&&start_rdy with start_ptr==NULL_PTR: the start is consumed, no beat is emitted, state stays IDLE.
  - Otherwise: cur<=start_ptr, hop_cnt<=0, state<=WALK. First beat is visible the next cycle (1-cycle latency).
- WALK:
  - start_rdy=0, busy=1, out_ptr_vld=1, out_ptr=cur.
  - nxt = table[cur[AW-1:0]] when cur<DEPTH; nxt = NULL_PTR when cur>=DEPTH (out-of-range pointer is emitted as a terminal beat).
  - out_last = (nxt==NULL_PTR) || (hop_cnt==MAX_HOPS-1). It is combinational and stable while vld is held.
- Handshake rules:
  - out_ptr and out_last are held stable while out_ptr_vld=1 && out_ptr_rdy=0.
  - On a handshake with out_last=0: cur<=nxt, hop_cnt++. Throughput is one beat per cycle with no bubbles.
  - On a handshake with out_last=1: state<=IDLE.
  - If the walk was cut by MAX_HOPS while nxt!=NULL_PTR, err_loop<=1.
  - There is one idle cycle between walks: start_rdy rises the cycle after the last beat.
- Table writes:
  - Accepted in any state, one per cycle.
  - A lookup in the same cycle as a write to the same index returns the old value (read-before-write).
- err_loop:
  - err_clr has priority over a simultaneous set.
  - err_loop does not block further walks.
- hop_cnt width is $clog2(MAX_HOPS+1). MAX_HOPS=1 gives single-beat walks.

Test Plan:
1. Program table 3->5, 5->2, 2->NULL; start_ptr=3 -> beats 3,5,2 on consecutive cycles starting 1 cycle after accept; out_last only on 2; start_rdy=1 one cycle later.
2. Same list with out_ptr_rdy low on cycles 2-4 -> out_ptr=5 held stable with vld=1; sequence unchanged; no beat duplicated or dropped.
3. Table 1->4, 4->1 (cycle), MAX_HOPS=16; start_ptr=1 -> exactly 16 beats alternating 1,4; last beat out_last=1; err_loop=1 the cycle after. Then err_clr -> err_loop=0.
4. start_ptr=NULL_PTR (0xFF) -> consumed, no beats, busy stays 0. Then start_ptr=0x20 (out of range) -> single beat 0x20 with out_last=1.
5. During walk at cur=5, write table[5]=7 in the handshake cycle -> next beat is the old value 2. A later walk from 5 yields 7.
6. Assert rst=0 mid-walk -> out_ptr_vld=0 and busy=0 immediately; table reads NULL; a new start from 3 emits a single beat 3 with out_last=1.

Source files
------------

// File: rtl/ll_walk_gen.sv
// ll_walk_gen: linked-list walker with a run-time programmable next-pointer table.
//
// A start pointer is accepted over start_vld/start_rdy. The walker emits the
// start pointer and every pointer reached through the next-table on the
// out_ptr valid/ready stream, flagging the final beat with out_last. A walk
// ends on NULL_PTR, on an out-of-range pointer (emitted as a terminal beat),
// or after MAX_HOPS beats, in which case sticky err_loop is raised.
//
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   cfg_we/addr/next    next-table write port, any state, read-before-write
//   start_ptr/vld/rdy   walk request handshake
//   out_ptr/vld/rdy     visited-pointer stream, out_last marks final beat
//   busy                walk in progress
//   err_loop, err_clr   sticky loop-abort flag and its synchronous clear
module ll_walk_gen #(
  parameter int unsigned      PTR_W    = 8,
  parameter int unsigned      DEPTH    = 16,
  parameter int unsigned      AW       = $clog2(DEPTH),
  parameter int unsigned      MAX_HOPS = DEPTH,
  parameter logic [PTR_W-1:0] NULL_PTR = {PTR_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [PTR_W-1:0] cfg_next,
  input  logic [PTR_W-1:0] start_ptr,
  input  logic             start_vld,
  output logic             start_rdy,
  output logic [PTR_W-1:0] out_ptr,
  output logic             out_ptr_vld,
  input  logic             out_ptr_rdy,
  output logic             out_last,
  output logic             busy,
  output logic             err_loop,
  input  logic             err_clr
);

  localparam int unsigned     HW       = $clog2(MAX_HOPS + 1);
  localparam logic [HW-1:0]   LAST_HOP = HW'(MAX_HOPS - 1);

  typedef enum logic {IDLE, WALK} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PTR_W-1:0] r_cur;
  logic [HW-1:0]    r_hop;
  logic             r_err;
  logic [PTR_W-1:0] r_tbl [DEPTH];

  logic             w_in_range;
  logic [PTR_W-1:0] w_nxt;
  logic             w_hop_last;
  logic             w_start_walk;
  logic             w_out_fire;
  logic             w_loop_abort;

  // Pointers at or above DEPTH have no table entry; they terminate the walk.
  assign w_in_range   = (r_cur[PTR_W-1:AW] == '0);
  assign w_nxt        = w_in_range ? r_tbl[r_cur[AW-1:0]] : NULL_PTR;
  assign w_hop_last   = (r_hop == LAST_HOP);
  assign w_start_walk = (r_state == IDLE) && start_vld && (start_ptr != NULL_PTR);
  assign w_out_fire   = (r_state == WALK) && out_ptr_rdy;
  // Cut by the hop limit while the list still continues.
  assign w_loop_abort = w_out_fire && w_hop_last && (w_nxt != NULL_PTR);
  assign err_loop     = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    start_rdy   = 1'b0;
    out_ptr_vld = 1'b0;
    out_ptr     = '0;
    out_last    = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Held low while in reset so no start is seen as accepted.
        start_rdy = rst;
        // A NULL start is consumed but keeps the walker idle.
        if (w_start_walk) begin
          w_state_nxt = WALK;
        end
      end
      WALK: begin
        busy        = 1'b1;
        out_ptr_vld = 1'b1;
        out_ptr     = r_cur;
        out_last    = (w_nxt == NULL_PTR) || w_hop_last;
        if (out_ptr_rdy && out_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur <= '0;
      r_hop <= '0;
      r_err <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_tbl[i] <= NULL_PTR;
      end
    end else begin
      // The lookup above reads the registered entry, so a same-cycle write
      // to the entry being followed only affects later lookups.
      if (cfg_we) begin
        r_tbl[cfg_addr] <= cfg_next;
      end

      if (w_start_walk) begin
        r_cur <= start_ptr;
        r_hop <= '0;
      end else if (w_out_fire && !out_last) begin
        r_cur <= w_nxt;
        r_hop <= r_hop + 1'b1;
      end

      if (err_clr) begin
        r_err <= 1'b0;
      end else if (w_loop_abort) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ll_walk_gen.sv
module tb_ll_walk_gen;

  localparam int unsigned PTR_W    = 8;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned MAX_HOPS = 16;
  localparam logic [7:0]  NULLP    = 8'hFF;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [7:0] cfg_next = '0;
  logic [7:0] start_ptr = '0;
  logic       start_vld = 1'b0;
  logic       start_rdy;
  logic [7:0] out_ptr;
  logic       out_ptr_vld;
  logic       out_ptr_rdy = 1'b1;
  logic       out_last;
  logic       busy;
  logic       err_loop;
  logic       err_clr = 1'b0;

  ll_walk_gen #(
    .PTR_W(PTR_W),
    .DEPTH(DEPTH),
    .MAX_HOPS(MAX_HOPS),
    .NULL_PTR(NULLP)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_next(cfg_next),
    .start_ptr(start_ptr), .start_vld(start_vld), .start_rdy(start_rdy),
    .out_ptr(out_ptr), .out_ptr_vld(out_ptr_vld), .out_ptr_rdy(out_ptr_rdy),
    .out_last(out_last), .busy(busy),
    .err_loop(err_loop), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ptr;
    logic       last;
    logic       abort;
  } beat_t;

  beat_t      q[$];
  logic [7:0] mtbl [DEPTH];
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: follow the list through the model table and queue every
  // pointer that should appear, tagging the terminal beat.
  function automatic void model_walk(input logic [7:0] head);
    logic [7:0] cur;
    logic [7:0] nxt;
    beat_t      b;
    if (head == NULLP) return;
    cur = head;
    for (int h = 0; h < int'(MAX_HOPS); h++) begin
      nxt     = (cur < DEPTH) ? mtbl[cur[3:0]] : NULLP;
      b.ptr   = cur;
      b.last  = (nxt == NULLP) || (h == int'(MAX_HOPS) - 1);
      b.abort = (nxt != NULLP) && (h == int'(MAX_HOPS) - 1);
      q.push_back(b);
      if (b.last) return;
      cur = nxt;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < int'(DEPTH); i++) mtbl[i] = NULLP;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] v);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_next = v;
    tick();
    cfg_we   = 1'b0;
    mtbl[a]  = v;
  endtask

  task automatic do_start(input logic [7:0] p);
    logic acc;
    acc       = 1'b0;
    start_ptr = p;
    start_vld = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = start_rdy;
      tick();
      if (acc) break;
    end
    start_vld = 1'b0;
    if (acc) model_walk(p);
    else chk("start_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q.size() == 0 && start_rdy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("walk_timeout", 32'd0, 32'd1);
    tick();
  endtask

  // Random backpressure and error clears, enabled in the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) begin
        out_ptr_rdy = ($urandom_range(0, 3) != 0);
        err_clr     = ($urandom_range(0, 15) == 0);
      end
    end
  end

  // Monitor: protocol invariants, stability under backpressure, beat order
  // against the scoreboard queue, and the sticky error flag.
  initial begin
    logic       err_exp;
    logic       p_set, p_clr, p_hold, h_last;
    logic [7:0] h_ptr;
    beat_t      e;
    err_exp = 1'b0; p_set = 1'b0; p_clr = 1'b0; p_hold = 1'b0;
    h_last = 1'b0; h_ptr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        err_exp = 1'b0; p_set = 1'b0; p_clr = 1'b0; p_hold = 1'b0;
      end else begin
        if (p_clr) err_exp = 1'b0;
        else if (p_set) err_exp = 1'b1;
        chk("err_loop", err_loop, err_exp);
        chk("out_ptr_vld", out_ptr_vld, q.size() != 0);
        chk("busy", busy, q.size() != 0);
        chk("start_rdy", start_rdy, q.size() == 0);
        if (p_hold) begin
          chk("hold_vld", out_ptr_vld, 1'b1);
          chk("hold_ptr", out_ptr, h_ptr);
          chk("hold_last", out_last, h_last);
        end
        p_set = 1'b0;
        if (out_ptr_vld && out_ptr_rdy) begin
          if (q.size() == 0) begin
            chk("unexpected_beat", out_ptr, 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("beat_ptr", out_ptr, e.ptr);
            chk("beat_last", out_last, e.last);
            p_set = e.abort;
          end
        end
        p_hold = out_ptr_vld && !out_ptr_rdy;
        h_ptr  = out_ptr;
        h_last = out_last;
        p_clr  = err_clr;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic [7:0] p;
    model_reset();

    // Reset values
    #12;
    chk("rst_vld", out_ptr_vld, 1'b0);
    chk("rst_ptr", out_ptr, 8'h00);
    chk("rst_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_loop, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk("rdy_after_rst", start_rdy, 1'b1);
    tick();

    // 1: simple list 3 -> 5 -> 2
    wr(4'd3, 8'd5);
    wr(4'd5, 8'd2);
    wr(4'd2, NULLP);
    do_start(8'd3);
    @(negedge clk);
    chk("t1_first_vld", out_ptr_vld, 1'b1);
    chk("t1_first_ptr", out_ptr, 8'd3);
    wait_idle();

    // 2: backpressure while 5 is presented
    do_start(8'd3);
    tick();
    out_ptr_rdy = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    chk("t2_held_ptr", out_ptr, 8'd5);
    chk("t2_held_vld", out_ptr_vld, 1'b1);
    tick();
    out_ptr_rdy = 1'b1;
    wait_idle();

    // 3: cycle 1 <-> 4 aborted at MAX_HOPS
    wr(4'd1, 8'd4);
    wr(4'd4, 8'd1);
    do_start(8'd1);
    wait_idle();
    chk("t3_err_set", err_loop, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t3_err_clr", err_loop, 1'b0);

    // 4: NULL start consumed, out-of-range start is a single beat
    do_start(NULLP);
    @(negedge clk);
    chk("t4_null_busy", busy, 1'b0);
    tick();
    do_start(8'h20);
    wait_idle();

    // 5: write table[5] in the cycle 5 is handed over
    do_start(8'd3);
    tick();
    chk("t5_at5", out_ptr, 8'd5);
    wr(4'd5, 8'd7);
    wait_idle();
    do_start(8'd3);
    wait_idle();

    // 6: reset mid-walk
    do_start(8'd3);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_vld", out_ptr_vld, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_last", out_last, 1'b0);
    q.delete();
    model_reset();
    tick(); tick();
    rst = 1'b1;
    tick();
    do_start(8'd3);
    wait_idle();

    // Random phase: reprogram while idle, random heads, random backpressure
    rdy_rand = 1'b1;
    for (int it = 0; it < 40; it++) begin
      for (int w = 0; w < 4; w++) begin
        case ($urandom_range(0, 3))
          0:       v = NULLP;
          1:       v = 8'($urandom_range(16, 254));
          default: v = 8'($urandom_range(0, 15));
        endcase
        wr(4'($urandom_range(0, 15)), v);
      end
      case ($urandom_range(0, 7))
        0:       p = NULLP;
        1:       p = 8'($urandom_range(16, 254));
        default: p = 8'($urandom_range(0, 15));
      endcase
      do_start(p);
      wait_idle();
    end
    rdy_rand    = 1'b0;
    out_ptr_rdy = 1'b1;
    err_clr     = 1'b0;
    tick(); tick();
    chk("queue_drained", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
